// File: rtl/ntt_result_unloader.sv
// ntt_result_unloader
// Captures one parallel result burst from ntt_processor into a
// 2 x 2^LOG_CORE_COUNT bank buffer, then streams it out one word per
// handshake in {half, core, local} address order.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | buffer free, waiting for the first in_active beat
// ST_CAPTURE | writing one beat per cycle while in_active stays high
// ST_DRAIN   | streaming all 2048 buffered words on m_valid/m_ready
module ntt_result_unloader #(
  parameter int LOG_CORE_COUNT = 5,
  parameter int DATA_WIDTH     = 60
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                in_active,
  input  logic [(1<<LOG_CORE_COUNT)-1:0][1:0][DATA_WIDTH-1:0] in_data,
  input  logic [8:0]                                          in_address,
  output logic                                                m_valid,
  input  logic                                                m_ready,
  output logic [DATA_WIDTH-1:0]                               m_data,
  output logic [10:0]                                         m_address,
  output logic                                                m_last,
  output logic                                                busy,
  output logic                                                overflow
);

  localparam int CORES   = 1 << LOG_CORE_COUNT;
  localparam int BANKS   = 2 * CORES;
  localparam int LOCAL_W = 10 - LOG_CORE_COUNT;
  localparam int BANK_W  = LOG_CORE_COUNT + 1;
  localparam int ADDR_W  = 11;
  localparam int WORDS   = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       r_q, r_d;
  logic                    all_loaded_q, all_loaded_d;
  logic                    m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic [ADDR_W-1:0]       m_address_q, m_address_d;
  logic                    m_last_q, m_last_d;
  logic                    overflow_q, overflow_d;
  logic                    wr_en;

  logic [DATA_WIDTH-1:0]   mem_q [WORDS];
  logic [BANKS-1:0][DATA_WIDTH-1:0] in_flat;
  logic [LOCAL_W-1:0]      wr_local;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    handshake;
  logic                    unused_addr_bits;

  // Bank b = {s, k} holds in_data[k][s], so the buffer address is {s, k, local}.
  for (genvar s = 0; s < 2; s++) begin : g_half
    for (genvar k = 0; k < CORES; k++) begin : g_core
      assign in_flat[s*CORES + k] = in_data[k][s];
    end
  end

  assign wr_local         = in_address[LOCAL_W-1:0];
  assign unused_addr_bits = ^in_address[8:LOCAL_W];
  assign rd_word          = mem_q[r_q];
  assign handshake        = m_valid_q & m_ready;

  // Buffer write: every bank takes its lane of the beat at the same local address.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BANKS; b++) begin
        mem_q[{BANK_W'(b), wr_local}] <= in_flat[BANK_W'(b)];
      end
    end
  end

  // Next-state, read index and output-register logic.
  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    all_loaded_d = all_loaded_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_address_d  = m_address_q;
    m_last_d     = m_last_q;
    overflow_d   = overflow_q;
    wr_en        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_active) begin
          wr_en   = 1'b1;
          state_d = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        if (in_active) begin
          wr_en = 1'b1;
        end else begin
          state_d      = ST_DRAIN;
          r_d          = '0;
          all_loaded_d = 1'b0;
        end
      end

      ST_DRAIN: begin
        if (handshake && m_last_q) begin
          // Final word accepted; a beat arriving on this same edge starts
          // the next capture instead of counting as an overflow.
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (in_active) begin
            wr_en   = 1'b1;
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (in_active) begin
            overflow_d = 1'b1;
          end
          if (!m_valid_q || m_ready) begin
            if (!all_loaded_q) begin
              m_valid_d   = 1'b1;
              m_data_d    = rd_word;
              m_address_d = r_q;
              m_last_d    = (r_q == LAST_IDX);
              r_d         = r_q + 1'b1;
              if (r_q == LAST_IDX) begin
                all_loaded_d = 1'b1;
              end
            end else begin
              m_valid_d = 1'b0;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      r_q          <= '0;
      all_loaded_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_address_q  <= '0;
      m_last_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      all_loaded_q <= all_loaded_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_address_q  <= m_address_d;
      m_last_q     <= m_last_d;
      overflow_q   <= overflow_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_address = m_address_q;
  assign m_last    = m_last_q;
  assign busy      = (state_q != ST_IDLE);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ntt_result_unloader.sv
// Directed bench for ntt_result_unloader: bursts are captured, the expected
// word stream is queued, and every accepted output word is popped and checked.
module tb_ntt_result_unloader;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_active;
  logic [31:0][1:0][59:0]  in_data;
  logic [8:0]              in_address;
  logic                    m_valid;
  logic                    m_ready;
  logic [59:0]             m_data;
  logic [10:0]             m_address;
  logic                    m_last;
  logic                    busy;
  logic                    overflow;

  typedef struct packed {
    logic [10:0] addr;
    logic [59:0] data;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc;

  always #5 clk = ~clk;

  ntt_result_unloader #(.LOG_CORE_COUNT(5), .DATA_WIDTH(60)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_active  (in_active),
    .in_data    (in_data),
    .in_address (in_address),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_address  (m_address),
    .m_last     (m_last),
    .busy       (busy),
    .overflow   (overflow)
  );

  function automatic logic [59:0] pat(input int burst, input logic [10:0] idx);
    logic [31:0] bv;
    logic [31:0] h;
    bv = burst;
    h  = {21'd0, idx} * 32'h9E37 + bv * 32'd7;
    return {bv[7:0], idx ^ 11'(bv * 37), h[29:0], idx};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic random_data();
    for (int k = 0; k < 32; k++)
      for (int s = 0; s < 2; s++)
        in_data[k][s] = {28'($urandom), $urandom};
  endtask

  task automatic drive_beat(input int burst, input int a);
    logic [4:0] al;
    al         = 5'(a);
    in_active  = 1'b1;
    in_address = {4'($urandom), al};
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 32; k++)
        in_data[k][s] = pat(burst, {1'(s), 5'(k), al});
  endtask

  // Drives beats start..31 on consecutive cycles, then drops in_active;
  // returns at the negedge just before the drain-entry edge.
  task automatic send_beats(input int burst, input int start);
    for (int a = start; a < 32; a++) begin
      @(negedge clk);
      drive_beat(burst, a);
    end
    @(negedge clk);
    in_active = 1'b0;
    random_data();
  endtask

  task automatic push_burst(input int burst);
    for (int i = 0; i < 2048; i++)
      q.push_back('{addr: 11'(i), data: pat(burst, 11'(i))});
  endtask

  task automatic drain(input int ready_pct, input int pulse_at, input int b2b,
                       input int rst_at, output int cycles);
    int          pulse_left;
    bit          done;
    bit          stall;
    logic [59:0] sd;
    logic [10:0] sa;
    logic        sl;
    exp_t        e;
    pulse_left = 0;
    done       = 1'b0;
    stall      = 1'b0;
    cycles     = 0;
    while (!done && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (stall) begin
        chk("hold_data", m_data, sd);
        chk("hold_addr", m_address, sa);
        chk("hold_last", m_last, sl);
      end
      m_ready = ($urandom_range(0, 99) < ready_pct);
      if (pulse_left > 0) begin
        drive_beat(99, $urandom_range(0, 31));
        pulse_left--;
      end else begin
        in_active = 1'b0;
      end
      if (m_valid && q.size() > 0 && rst_at >= 0 && int'(q[0].addr) == rst_at) begin
        rst_n   = 1'b0;
        m_ready = 1'b0;
        done    = 1'b1;
      end else if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          chk("extra_word", 1, 0);
          done = 1'b1;
        end else begin
          e = q.pop_front();
          chk("word_addr", m_address, e.addr);
          chk("word_data", m_data, e.data);
          chk("word_last", m_last, e.addr == 11'h7FF);
          if (int'(e.addr) == pulse_at) begin
            drive_beat(99, $urandom_range(0, 31));
            pulse_left = 2;
          end
          if (e.addr == 11'h7FF) begin
            done = 1'b1;
            if (b2b > 0) drive_beat(b2b, 0);
          end
        end
      end
      stall = m_valid && !m_ready && !done;
      sd    = m_data;
      sa    = m_address;
      sl    = m_last;
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_active  = 1'b0;
    m_ready    = 1'b0;
    in_address = '0;
    in_data    = '0;

    // Reset with random inputs
    repeat (2) begin
      @(negedge clk);
      in_active  = 1'($urandom_range(0, 1));
      m_ready    = 1'($urandom_range(0, 1));
      in_address = 9'($urandom);
      random_data();
    end
    @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_data", m_data, 0);
    chk("rst_addr", m_address, 0);
    rst_n     = 1'b1;
    in_active = 1'b0;
    m_ready   = 1'b1;

    // Full burst, m_ready held high
    send_beats(1, 0);
    chk("capture_busy", busy, 1);
    push_burst(1);
    @(negedge clk);
    chk("entry_valid", m_valid, 0);
    chk("entry_busy", busy, 1);
    drain(100, -1, 0, -1, cyc);
    chk("full_cycles", cyc, 2048);
    chk("full_queue_empty", q.size(), 0);
    @(negedge clk);
    chk("full_idle_busy", busy, 0);
    chk("full_idle_valid", m_valid, 0);
    chk("full_overflow", overflow, 0);

    // Backpressure, 50% ready
    send_beats(2, 0);
    push_burst(2);
    @(negedge clk);
    drain(50, -1, 0, -1, cyc);
    chk("bp_queue_empty", q.size(), 0);
    @(negedge clk);
    chk("bp_idle_busy", busy, 0);

    // Back-to-back: next burst's first beat on the final handshake edge
    send_beats(3, 0);
    push_burst(3);
    @(negedge clk);
    drain(100, -1, 4, -1, cyc);
    chk("b2b_first_queue_empty", q.size(), 0);
    send_beats(4, 1);
    chk("b2b_overflow", overflow, 0);
    chk("b2b_capture_busy", busy, 1);
    push_burst(4);
    @(negedge clk);
    chk("b2b_entry_valid", m_valid, 0);
    drain(70, -1, 0, -1, cyc);
    chk("b2b_queue_empty", q.size(), 0);
    @(negedge clk);
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_overflow_end", overflow, 0);

    // Overflow: 3-cycle in_active pulse at word 100
    send_beats(5, 0);
    push_burst(5);
    @(negedge clk);
    drain(100, 100, 0, -1, cyc);
    chk("ovf_cycles", cyc, 2048);
    chk("ovf_set", overflow, 1);
    chk("ovf_queue_empty", q.size(), 0);
    @(negedge clk);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_idle_busy", busy, 0);

    // Reset mid-drain at word 500
    send_beats(6, 0);
    push_burst(6);
    @(negedge clk);
    drain(100, -1, 0, 500, cyc);
    @(negedge clk);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_addr", m_address, 0);
    chk("mid_rst_last", m_last, 0);
    q.delete();
    rst_n = 1'b1;

    // Fresh burst after reset drains from address 0
    send_beats(7, 0);
    push_burst(7);
    @(negedge clk);
    drain(100, -1, 0, -1, cyc);
    chk("post_rst_cycles", cyc, 2048);
    chk("post_rst_queue_empty", q.size(), 0);
    @(negedge clk);
    chk("post_rst_idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
